// File: rtl/reg_save_restore_pkg.sv
// Shared types and constants for the register save/restore sequencer.
package reg_save_restore_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic MODE_SAVE    = 1'b0;
  localparam logic MODE_RESTORE = 1'b1;

endpackage

// File: rtl/reg_save_restore.sv
// Streams a window of the register file out (save) or back in (restore),
// one register per handshake, starting at Base and wrapping modulo 2**D.
//
// state   | meaning
// IDLE    | waiting for Start; Base/Len captured on the Start edge
// SAVE    | RdData at the address counter offered on the So stream
// RESTORE | Si stream beats written to the register file
// DONE    | one-cycle Done pulse, then back to IDLE
module reg_save_restore
  import reg_save_restore_pkg::*;
#(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Mode,
  input  logic [D-1:0] Base,
  input  logic [D:0]   Len,
  output logic         Busy,
  output logic         Done,
  output logic [D-1:0] RaddrA,
  input  logic [W-1:0] RdData,
  output logic [D-1:0] Waddr,
  output logic         WriteEn,
  output logic [W-1:0] WrData,
  output logic         SoValid,
  input  logic         SoReady,
  output logic [W-1:0] SoData,
  input  logic         SiValid,
  output logic         SiReady,
  input  logic [W-1:0] SiData
);

  state_t       state, state_nxt;
  logic [D-1:0] addr_q;
  logic [D:0]   remaining_q;
  logic         so_fire;
  logic         si_fire;
  logic         last_beat;
  logic         start_take;

  assign so_fire    = (state == ST_SAVE) && SoReady;
  assign si_fire    = (state == ST_RESTORE) && SiValid;
  assign last_beat  = (remaining_q == (D+1)'(1));
  assign start_take = (state == ST_IDLE) && Start;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (Start) begin
          if (Len == '0)              state_nxt = ST_DONE;
          else if (Mode == MODE_SAVE) state_nxt = ST_SAVE;
          else                        state_nxt = ST_RESTORE;
        end
      end
      ST_SAVE:    if (so_fire && last_beat) state_nxt = ST_DONE;
      ST_RESTORE: if (si_fire && last_beat) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Address wraps naturally at D bits; remaining only counts down to zero.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      addr_q      <= '0;
      remaining_q <= '0;
    end else if (start_take) begin
      addr_q      <= Base;
      remaining_q <= Len;
    end else if (so_fire || si_fire) begin
      addr_q      <= addr_q + D'(1);
      remaining_q <= remaining_q - (D+1)'(1);
    end
  end

  // Control outputs are masked by Reset so an aborting cycle cannot write.
  always_comb begin
    Busy    = 1'b0;
    Done    = 1'b0;
    SoValid = 1'b0;
    SiReady = 1'b0;
    WriteEn = 1'b0;
    if (!Reset) begin
      case (state)
        ST_SAVE: begin
          Busy    = 1'b1;
          SoValid = 1'b1;
        end
        ST_RESTORE: begin
          Busy    = 1'b1;
          SiReady = 1'b1;
          WriteEn = SiValid;
        end
        ST_DONE: Done = 1'b1;
        default: ;
      endcase
    end
  end

  assign RaddrA = addr_q;
  assign Waddr  = addr_q;
  assign SoData = RdData;
  assign WrData = SiData;

endmodule

// File: doc/reg_save_restore.md
REG_SAVE_RESTORE -- requirements
Module: reg_save_restore

Interface
REQ-001 Parameters: W, default 8, data path width; D, default 4, register address width (2**D registers).
REQ-002 Clk  input  1  clock; all state updates on posedge Clk.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 Mode  input  1  0 = save (register file -> stream out), 1 = restore (stream in -> register file); sampled with Start.
REQ-006 Base  input  D  first register address; sampled with Start.
REQ-007 Len  input  D+1  number of registers to transfer (0..2**D); sampled with Start.
REQ-008 Busy  output  1  high in SAVE or RESTORE.
REQ-009 Done  output  1  one-cycle pulse when a transfer completes.
REQ-010 RaddrA  output  D  register file read address.
REQ-011 RdData  input  W  combinational read data returned for RaddrA.
REQ-012 Waddr  output  D  register file write address.
REQ-013 WriteEn  output  1  register file write enable.
REQ-014 WrData  output  W  register file write data.
REQ-015 SoValid / SoReady / SoData  output / input / output  1/1/W  save stream; beat transfers when SoValid && SoReady.
REQ-016 SiValid / SiReady / SiData  input / output / input  1/1/W  restore stream; beat transfers when SiValid && SiReady.

Function
REQ-017 FSM states: IDLE, SAVE, RESTORE, DONE.
REQ-018 IDLE: Start=1, Len>0, Mode=0 -> SAVE; Start=1, Len>0, Mode=1 -> RESTORE; Start=1, Len=0 -> DONE; Start=0 -> stay.
REQ-019 On leaving IDLE, the address counter loads Base and the remaining counter loads Len.
REQ-020 SAVE: RaddrA = address counter; SoData = RdData (combinational); SoValid = 1; SiReady = 0; WriteEn = 0.
REQ-021 SAVE: each SoValid && SoReady cycle increments the address modulo 2**D and decrements remaining; SoValid and SoData are held stable while SoReady=0.
REQ-022 RESTORE: SiReady = 1; WriteEn = SiValid; Waddr = address counter; WrData = SiData (combinational, zero added latency); SoValid = 0.
REQ-023 RESTORE: each SiValid && SiReady cycle performs exactly one register write, increments the address modulo 2**D, and decrements remaining.
REQ-024 The final beat (remaining = 1 on a handshake) moves to DONE on the next edge; no further handshakes occur.
REQ-025 DONE: Done = 1 for exactly one cycle, Busy = 0, then -> IDLE unconditionally.
REQ-026 Address wrap: Base = 2**D-2, Len = 4 accesses addresses 14, 15, 0, 1 (D=4).
REQ-027 Len = 2**D transfers every register exactly once.
REQ-028 Start while Busy or in DONE is ignored; it is neither queued nor does it alter the transfer in progress.
REQ-029 Outside SAVE: SoValid = 0. Outside RESTORE: SiReady = 0 and WriteEn = 0. RaddrA, Waddr, WrData and SoData may hold any value when not qualified.
REQ-030 Throughput: one register per cycle when the stream partner is always ready/valid, so a transfer of Len registers takes Len+1 cycles from the Start edge to the Done pulse.

Reset
REQ-031 Reset forces IDLE, clears the address and remaining counters, and drives Busy = 0, Done = 0, SoValid = 0, SiReady = 0, WriteEn = 0.
REQ-032 Reset mid-transfer aborts the transfer: no Done pulse and no further writes; registers already written keep their values.
REQ-033 Reset takes priority over Start and over any handshake in the same cycle.

Structure
REQ-034 A shared package reg_save_restore_pkg holds the state enum and the MODE_SAVE/MODE_RESTORE constants.
REQ-035 Single module with no sub-modules; the bench instantiates it alongside the team register file (W=8, D=4), with RaddrA/RdData connected to read port A.

Verification
REQ-036 Save all: registers preloaded with i*3, Start Mode=0, Base=0, Len=16, SoReady=1 -> 16 beats 0x00, 0x03, .., 0x2D on consecutive cycles, then one Done pulse.
REQ-037 Restore with wrap: Start Mode=1, Base=14, Len=4, SiData 0xA1..0xA4 -> regs 14, 15, 0, 1 = 0xA1..0xA4; all others unchanged.
REQ-038 Backpressure: SoReady toggled 1,0,0,1 during a save of Base=5, Len=3 -> SoData holds each value while stalled; exactly 3 beats, regs 5..7 in order.
REQ-039 Len=0: Start -> Done pulse one cycle later, no SoValid and no WriteEn.
REQ-040 Reset mid-restore after 2 of 4 beats -> IDLE, Busy=0, no Done pulse, only 2 registers written.
REQ-041 Start asserted while Busy -> ignored; the original Len and Base complete and no second transfer follows.
